// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a 1024x8 single-port memory among NREQ requesters,
// with an optional post-reset zero-fill pass before requests are served.
module mem_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned INIT_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*10-1:0] req_addr,
  input  logic [NREQ*8-1:0]  req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [7:0]         rsp_rdata,
  output logic               init_done,
  output logic               mem_wen,
  output logic [9:0]         mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [9:0]      cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            init_done_q, init_done_d;
  logic            mem_wen_q, mem_wen_d;
  logic [9:0]      mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            cmd_rd_q, cmd_rd_d;
  logic [PW-1:0]   cmd_id_q, cmd_id_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_rdata_q, rsp_rdata_d;

  logic            grant_valid;
  logic [PW-1:0]   grant_id;
  logic [PW-1:0]   cand;
  logic            init_last;
  logic            sel_wen;
  logic [9:0]      sel_addr;
  logic [7:0]      sel_wdata;

  // The mem_* registers double as the init write port and the cmd stage, so the
  // last zero-fill write is the one currently presented at address 1023.
  assign init_last = (state_q == ST_INIT) && mem_wen_q && (mem_addr_q == 10'h3FF);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = PW'((32'(ptr_q) + k) % NREQ);
      if (!grant_valid && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == PW'(i)) begin
        sel_wen   = req_wen[i];
        sel_addr  = req_addr[10*i +: 10];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (INIT_EN == 0 || init_last) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_RUN && grant_valid) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q || (state_d == ST_RUN);
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cmd_rd_d    = 1'b0;
    cmd_id_d    = cmd_id_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (cmd_rd_q) begin
      rsp_valid_d[cmd_id_q] = 1'b1;
      rsp_rdata_d           = mem_rdata;
    end
    if (state_q == ST_INIT && INIT_EN != 0 && !init_last) begin
      mem_wen_d   = 1'b1;
      mem_addr_d  = cnt_q;
      mem_wdata_d = '0;
      if (cnt_q != 10'h3FF) cnt_d = cnt_q + 10'd1;
    end else if (state_q == ST_RUN && grant_valid) begin
      mem_wen_d   = sel_wen;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      cmd_rd_d    = !sel_wen;
      cmd_id_d    = grant_id;
      ptr_d       = grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ptr_q       <= PW'(NREQ - 1);
      init_done_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cmd_rd_q    <= 1'b0;
      cmd_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_id_q    <= cmd_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written corner sequences and random
// traffic checked against a queue-based reference of the arbitration rules.
module tb_mem_arbiter;
  localparam int NREQ = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid, req_ready, req_wen, rsp_valid;
  logic [NREQ*10-1:0] req_addr;
  logic [NREQ*8-1:0]  req_wdata;
  logic [7:0]         rsp_rdata, mem_wdata, mem_rdata;
  logic               init_done, mem_wen;
  logic [9:0]         mem_addr;

  mem_arbiter #(.NREQ(NREQ), .INIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    int         id;
    logic       wen;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    int          id;
    logic [7:0]  data;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;
  int unsigned cyc    = 0;
  int unsigned ref_ptr;
  logic [7:0]  ref_mem [1024];
  exp_t        expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_mem_wen"},   mem_wen,   0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic set_req(input int id, input logic wen, input logic [9:0] a, input logic [7:0] d);
    req_wen[id]          = wen;
    req_addr[10*id +: 10] = a;
    req_wdata[8*id +: 8]  = d;
  endtask

  task automatic wait_ready(input int id);
    bit ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1'b1; break; end
    end
    chk("grant_wait", ok, 1);
  endtask

  // Watches one full zero-fill pass; requests are held valid to prove they are refused.
  task automatic run_init();
    int unsigned pulses = 0;
    logic [9:0]  exp_a  = '0;
    bit          seq_ok = 1'b1;
    bit          rdy_ok = 1'b1;
    bit          done   = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (init_done) begin done = 1'b1; break; end
      if (req_ready != '0) rdy_ok = 1'b0;
      if (mem_wen) begin
        if (mem_addr !== exp_a || mem_wdata !== 8'h00) seq_ok = 1'b0;
        exp_a++;
        pulses++;
      end
    end
    req_valid = '0;
    chk("init_done_rise", done, 1);
    chk("init_pulses", pulses, 1024);
    chk("init_addr_seq", seq_ok, 1);
    chk("init_ready_low", rdy_ok, 1);
    chk("post_init_wen", mem_wen, 0);
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    ref_ptr = NREQ - 1;
  endtask

  vec_t            vecs [12];
  logic [NREQ-1:0] oh;
  logic [NREQ-1:0] acc;

  initial begin
    vecs[0]  = '{0, 1'b1, 10'h2FF, 8'h5A, 8'h00};
    vecs[1]  = '{0, 1'b0, 10'h2FF, 8'h00, 8'h5A};
    vecs[2]  = '{0, 1'b1, 10'h010, 8'h11, 8'h00};
    vecs[3]  = '{1, 1'b1, 10'h110, 8'h22, 8'h00};
    vecs[4]  = '{0, 1'b1, 10'h210, 8'h33, 8'h00};
    vecs[5]  = '{1, 1'b1, 10'h310, 8'h44, 8'h00};
    vecs[6]  = '{0, 1'b0, 10'h010, 8'h00, 8'h11};
    vecs[7]  = '{1, 1'b0, 10'h110, 8'h00, 8'h22};
    vecs[8]  = '{0, 1'b0, 10'h210, 8'h00, 8'h33};
    vecs[9]  = '{1, 1'b0, 10'h310, 8'h00, 8'h44};
    vecs[10] = '{0, 1'b0, 10'h000, 8'h00, 8'h00};
    vecs[11] = '{1, 1'b0, 10'h3FF, 8'h00, 8'h00};

    // Reference monitor: grants rotate from the last winner, reads return the
    // most recently accepted write to that address two edges after acceptance.
    fork
      begin
        int         win;
        int         cand;
        logic [NREQ-1:0] exp_v;
        exp_t       e;
        logic [9:0] a;
        forever begin
          @(negedge clk);
          cyc++;
          if (chk_en) begin
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
              e = expq.pop_front();
              exp_v = '0;
              exp_v[e.id] = 1'b1;
              chk("model_rsp_valid", rsp_valid, exp_v);
              chk("model_rsp_rdata", rsp_rdata, e.data);
            end else begin
              chk("model_rsp_idle", rsp_valid, 0);
            end
            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
              cand = (ref_ptr + k) % NREQ;
              if (win < 0 && req_valid[cand]) win = cand;
            end
            exp_v = '0;
            if (win >= 0) exp_v[win] = 1'b1;
            chk("model_req_ready", req_ready, exp_v);
            if (win >= 0) begin
              ref_ptr = win;
              a = req_addr[10*win +: 10];
              if (req_wen[win]) ref_mem[a] = req_wdata[8*win +: 8];
              else begin
                e.cyc  = cyc + 2;
                e.id   = win;
                e.data = ref_mem[a];
                expq.push_back(e);
              end
            end
          end
        end
      end
    join_none

    rst_n = 1'b0; req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    #3;
    chk_reset_outputs("rst");
    set_req(0, 1'b0, 10'h001, 8'h00);
    set_req(1, 1'b0, 10'h002, 8'h00);
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_init();
    @(posedge clk); #1 chk_en = 1'b1;

    for (int v = 0; v < 12; v++) begin
      @(posedge clk); #1;
      set_req(vecs[v].id, vecs[v].wen, vecs[v].addr, vecs[v].wdata);
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      wait_ready(vecs[v].id);
      @(posedge clk); #1 req_valid = '0;
      if (!vecs[v].wen) begin
        @(posedge clk); #1;
        oh = '0;
        oh[vecs[v].id] = 1'b1;
        chk("vec_rsp_valid", rsp_valid, oh);
        chk("vec_rsp_rdata", rsp_rdata, vecs[v].exp_rdata);
      end
    end

    // Both requesters reading continuously: grants must alternate starting at 0.
    @(posedge clk); #1;
    set_req(0, 1'b0, 10'h010, 8'h00);
    set_req(1, 1'b0, 10'h110, 8'h00);
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_grant", req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);

    // Write by req1 then read of the same address by req0 on the next cycle.
    #1;
    set_req(1, 1'b1, 10'h080, 8'hA5);
    req_valid = 2'b10;
    @(negedge clk); chk("raw_wr_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    set_req(0, 1'b0, 10'h080, 8'h00);
    req_valid = 2'b01;
    @(negedge clk); chk("raw_rd_grant", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    chk("raw_rsp_valid", rsp_valid, 2'b01);
    chk("raw_rsp_rdata", rsp_rdata, 8'hA5);

    acc = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, 1'($urandom_range(0, 1)), {2'($urandom), 5'b0, 3'($urandom)}, 8'($urandom));
        end
      end
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Reset asserted right after a read is accepted: its response must never appear.
    #1 chk_en = 1'b0;
    set_req(0, 1'b0, 10'h2FF, 8'h00);
    req_valid = 2'b01;
    wait_ready(0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    expq.delete();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("midrst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reinit_wen", mem_wen, 1);
    chk("reinit_addr", mem_addr, 0);
    chk("reinit_done_low", init_done, 0);
    chk("reinit_no_rsp", rsp_valid, 0);
    run_init();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
